mac_accumulator: RTL and testbench
==================================

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, operand width of the upstream booth_multiplier.
REQ-002 SHALL have parameter ACC_WIDTH, default 16, accumulator width; ACC_WIDTH >= 2*DATA_WIDTH, checked at elaboration.
REQ-003 SHALL have port clk_in  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port producto_in  input  2*DATA_WIDTH signed  product from booth_multiplier resultado_out.
REQ-006 SHALL have port producto_valid_in  input  1  producto_in is valid this cycle.
REQ-007 SHALL have port last_in  input  1  marks the final term of a dot product; qualified by producto_valid_in.
REQ-008 SHALL have port clear_in  input  1  aborts and zeroes the running sum.
REQ-009 SHALL have port resultado_ready_in  input  1  downstream accepts resultado_out.
REQ-010 SHALL have port ready_out  output  1  block accepts a product this cycle.
REQ-011 SHALL have port resultado_out  output  ACC_WIDTH signed  completed sum.
REQ-012 SHALL have port resultado_valid_out  output  1  resultado_out is valid.
REQ-013 SHALL have port cuenta_out  output  8  number of terms in the current/held sum.
REQ-014 SHALL have port overflow_out  output  1  sticky signed-overflow flag for the current/held sum.

Function
REQ-015 SHALL implement a two-state FSM: ACUM (accepting terms) and DONE (holding result).
REQ-016 SHALL drive ready_out = 1 in ACUM and 0 in DONE.
REQ-017 SHALL accept a term when producto_valid_in && ready_out; acc <= acc + sign-extended producto_in; cuenta increments.
REQ-018 SHALL, on an accepted term with last_in = 1, load resultado_out with the final sum, enter DONE, and assert resultado_valid_out on the next cycle (latency 1).
REQ-019 SHALL zero the internal accumulator when entering DONE, so the next dot product starts from 0.
REQ-020 SHALL hold resultado_out, cuenta_out, overflow_out and resultado_valid_out stable in DONE until resultado_ready_in = 1.
REQ-021 SHALL, on resultado_valid_out && resultado_ready_in, return to ACUM, deassert resultado_valid_out and zero cuenta_out and overflow_out on the next cycle.
REQ-022 SHALL ignore producto_valid_in and last_in in DONE.
REQ-023 SHALL let clear_in take priority over a simultaneous product: zero acc, cuenta and overflow and discard that product.
REQ-024 SHALL, on clear_in in DONE, drop the held result, deassert resultado_valid_out and return to ACUM.
REQ-025 SHALL detect signed overflow of each ACC_WIDTH addition and set overflow_out sticky until clear, result handshake or reset.
REQ-026 SHALL saturate cuenta_out at 255 and never wrap it.
REQ-027 SHALL treat last_in without producto_valid_in as no-op.

Reset
REQ-028 SHALL, on rst_in = 1 at a clock edge, enter ACUM with acc = 0, resultado_out = 0, resultado_valid_out = 0, cuenta_out = 0 and overflow_out = 0.
REQ-029 SHALL discard any partial or held sum when reset is asserted mid-operation; ready_out = 1 in the first cycle after reset deasserts.

Configuration
REQ-030 SHALL, with MAC_SATURATE_EN defined, clamp an overflowing sum to the signed max (2^(ACC_WIDTH-1)-1) or min (-2^(ACC_WIDTH-1)) and keep it clamped for later terms.
REQ-031 SHALL, without MAC_SATURATE_EN, wrap modulo 2^ACC_WIDTH; overflow_out behaves identically in both builds.

Structure
REQ-032 SHALL take the FSM state enum (ACUM, DONE) and the counter width constant (8) from shared package mac_pkg.
REQ-033 SHALL place the add, overflow detection and optional saturation in one combinational sub-module, mac_sat_adder, parameterised by ACC_WIDTH.

Verification
REQ-034 SHALL cover a basic sum (DATA_WIDTH=4, ACC_WIDTH=16): products 12, -5, 7 (last) on consecutive cycles -> next cycle resultado_out = 14, cuenta_out = 3, overflow_out = 0, resultado_valid_out = 1.
REQ-035 SHALL cover overflow (ACC_WIDTH=8): products 64, 64 (last) -> overflow_out = 1; resultado_out = 127 with MAC_SATURATE_EN, -128 without.
REQ-036 SHALL cover backpressure: result valid with resultado_ready_in low for 3 cycles while producto_valid_in = 1 -> result held, ready_out = 0, no terms absorbed; ready high -> ACUM next cycle, cuenta_out = 0.
REQ-037 SHALL cover clear collision: clear_in and producto_valid_in = 1 (value 9) in the same cycle after sum 20 -> acc = 0, cuenta_out = 0, and a subsequent term 3 (last) gives resultado_out = 3.
REQ-038 SHALL cover mid-operation reset: rst_in pulsed after 2 of 4 terms -> all outputs 0, ready_out = 1; a fresh 2-term sum 4, 4 (last) gives 8.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulator slice.
package mac_pkg;

  typedef enum logic {
    ACUM = 1'b0,
    DONE = 1'b1
  } mac_state_e;

  localparam int unsigned CNT_WIDTH = 8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

endpackage

// File: rtl/mac_sat_adder.sv
// Combinational ACC_WIDTH signed adder with overflow detect.
// MAC_SATURATE_EN clamps an overflowing sum; otherwise it wraps.
module mac_sat_adder #(
  parameter int unsigned ACC_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0] a_i,
  input  logic signed [ACC_WIDTH-1:0] b_i,
  output logic signed [ACC_WIDTH-1:0] sum_o,
  output logic                        ovf_o
);

  logic signed [ACC_WIDTH-1:0] raw;

  always_comb begin
    raw   = a_i + b_i;
    // Same-sign operands producing an opposite-sign result is signed overflow.
    ovf_o = (a_i[ACC_WIDTH-1] == b_i[ACC_WIDTH-1]) &&
            (raw[ACC_WIDTH-1] != a_i[ACC_WIDTH-1]);
`ifdef MAC_SATURATE_EN
    if (ovf_o) begin
      sum_o = a_i[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                               : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      sum_o = raw;
    end
`else
    sum_o = raw;
`endif
  end

endmodule

// File: rtl/mac_accumulator.sv
// Multiply-accumulate back end: sums booth_multiplier products into a dot product.
// Build option MAC_SATURATE_EN selects saturating instead of wrapping sums.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ACC_WIDTH  = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic signed [2*DATA_WIDTH-1:0] producto_in,
  input  logic                          producto_valid_in,
  input  logic                          last_in,
  input  logic                          clear_in,
  input  logic                          resultado_ready_in,
  output logic                          ready_out,
  output logic signed [ACC_WIDTH-1:0]   resultado_out,
  output logic                          resultado_valid_out,
  output logic [CNT_WIDTH-1:0]          cuenta_out,
  output logic                          overflow_out
);

  if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_width_chk
    $error("mac_accumulator: ACC_WIDTH must be >= 2*DATA_WIDTH");
  end

  mac_state_e                  state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] res_q, res_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic                        ovf_q, ovf_d;

  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] add_sum;
  logic signed [ACC_WIDTH-1:0] next_acc;
  logic                        add_ovf;

  assign prod_ext = ACC_WIDTH'(producto_in);

  mac_sat_adder #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_adder (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

`ifdef MAC_SATURATE_EN
  // Once saturated, later terms must not pull the sum back off the rail.
  assign next_acc = ovf_q ? acc_q : add_sum;
`else
  assign next_acc = add_sum;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ACUM: begin
        if (clear_in) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (producto_valid_in) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
          ovf_d = ovf_q | add_ovf;
          if (last_in) begin
            res_d   = next_acc;
            acc_d   = '0;
            state_d = DONE;
          end else begin
            acc_d = next_acc;
          end
        end
      end
      DONE: begin
        if (clear_in) begin
          state_d = ACUM;
          acc_d   = '0;
          res_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (resultado_ready_in) begin
          state_d = ACUM;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACUM;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ACUM;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready_out           = (state_q == ACUM);
  assign resultado_valid_out = (state_q == DONE);
  assign resultado_out       = res_q;
  assign cuenta_out          = cnt_q;
  assign overflow_out        = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a 16-bit instance for the main
// table and corner sequences, an 8-bit instance for overflow.
module tb_mac_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit accumulator instance
  logic              rst, vld, lst, clr, rrdy;
  logic signed [7:0] prod;
  logic              ready;
  logic signed [15:0] res;
  logic              rvalid;
  logic [7:0]        cnt;
  logic              ovf;

  mac_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(16)) dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .producto_in        (prod),
    .producto_valid_in  (vld),
    .last_in            (lst),
    .clear_in           (clr),
    .resultado_ready_in (rrdy),
    .ready_out          (ready),
    .resultado_out      (res),
    .resultado_valid_out(rvalid),
    .cuenta_out         (cnt),
    .overflow_out       (ovf)
  );

  // 8-bit accumulator instance
  logic              vld8, lst8, rrdy8;
  logic signed [7:0] prod8;
  logic              ready8;
  logic signed [7:0] res8;
  logic              rvalid8;
  logic [7:0]        cnt8;
  logic              ovf8;

  mac_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(8)) dut8 (
    .clk_in             (clk),
    .rst_in             (rst),
    .producto_in        (prod8),
    .producto_valid_in  (vld8),
    .last_in            (lst8),
    .clear_in           (1'b0),
    .resultado_ready_in (rrdy8),
    .ready_out          (ready8),
    .resultado_out      (res8),
    .resultado_valid_out(rvalid8),
    .cuenta_out         (cnt8),
    .overflow_out       (ovf8)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic v, input logic l,
                       input logic r, input logic signed [7:0] p);
    clr  = c;
    vld  = v;
    lst  = l;
    rrdy = r;
    prod = p;
  endtask

  task automatic chk_all(input string tag, input int e_ready, input int e_valid,
                         input int e_res, input int e_cnt, input int e_ovf);
    chk({tag, "_ready"}, int'(ready),  e_ready);
    chk({tag, "_valid"}, int'(rvalid), e_valid);
    chk({tag, "_res"},   int'(res),    e_res);
    chk({tag, "_cnt"},   int'(cnt),    e_cnt);
    chk({tag, "_ovf"},   int'(ovf),    e_ovf);
  endtask

  typedef struct {
    logic              clr;
    logic              vld;
    logic              lst;
    logic              rdy;
    logic signed [7:0] prod;
    int                e_ready;
    int                e_valid;
    int                e_res;
    int                e_cnt;
    int                e_ovf;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // clr vld lst rdy prod | ready valid res cnt ovf  (state after the edge)
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0,  8'sd0,  1, 0,    0, 0, 0}; // idle
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0,  8'sd12, 1, 0,    0, 1, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, -8'sd5,  1, 0,    0, 2, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0,  8'sd7,  0, 1,   14, 3, 0}; // 12-5+7
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0,  8'sd5,  0, 1,   14, 3, 0}; // backpressure
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0,  8'sd5,  0, 1,   14, 3, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0,  8'sd5,  0, 1,   14, 3, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1,  8'sd5,  1, 0,   14, 0, 0}; // handshake
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0,  8'sd20, 1, 0,   14, 1, 0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0,  8'sd9,  1, 0,   14, 0, 0}; // clear wins
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0,  8'sd50, 1, 0,   14, 0, 0}; // last w/o valid
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0,  8'sd3,  0, 1,    3, 1, 0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1,  8'sd0,  1, 0,    3, 0, 0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, -8'sd128,1, 0,    3, 1, 0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, -8'sd1,  0, 1, -129, 2, 0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0,  8'sd0,  1, 0,    0, 0, 0}; // clear in DONE

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'sd0);
    vld8 = 1'b0; lst8 = 1'b0; rrdy8 = 1'b0; prod8 = 8'sd0;
    step();
    step();
    rst = 1'b0;
    chk_all("reset", 1, 0, 0, 0, 0);

    for (int unsigned i = 0; i < 16; i++) begin
      drive(tbl[i].clr, tbl[i].vld, tbl[i].lst, tbl[i].rdy, tbl[i].prod);
      step();
      chk_all($sformatf("v%0d", i), tbl[i].e_ready, tbl[i].e_valid,
              tbl[i].e_res, tbl[i].e_cnt, tbl[i].e_ovf);
    end

    // Mid-operation reset after 2 of 4 terms, with a product present.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'sd1);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'sd2);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'sd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'sd0);
    chk_all("midrst", 1, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'sd4);
    step();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'sd4);
    step();
    chk_all("fresh", 0, 1, 8, 2, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'sd0);
    step();
    chk("fresh_ack_ready", int'(ready), 1);

    // Term counter saturates at 255 rather than wrapping.
    for (int unsigned i = 0; i < 255; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'sd1);
      step();
    end
    chk("cnt_255", int'(cnt), 255);
    step();
    chk("cnt_sat", int'(cnt), 255);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'sd1);
    step();
    chk("cnt_sat_last", int'(cnt), 255);
    chk("cnt_sat_res", int'(res), 257);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'sd0);
    step();
    chk("cnt_sat_ack", int'(cnt), 0);

    // 8-bit overflow: 64 + 64.
    vld8 = 1'b1; lst8 = 1'b0; prod8 = 8'sd64;
    step();
    chk("ovf8_first", int'(ovf8), 0);
    lst8 = 1'b1;
    step();
    vld8 = 1'b0; lst8 = 1'b0;
    chk("ovf8_flag", int'(ovf8), 1);
    chk("ovf8_valid", int'(rvalid8), 1);
    chk("ovf8_cnt", int'(cnt8), 2);
`ifdef MAC_SATURATE_EN
    chk("ovf8_res", int'(res8), 127);
`else
    chk("ovf8_res", int'(res8), -128);
`endif
    rrdy8 = 1'b1;
    step();
    rrdy8 = 1'b0;
    chk("ovf8_ack_flag", int'(ovf8), 0);
    chk("ovf8_ack_ready", int'(ready8), 1);

    // Sticky overflow across a later non-overflowing term: 64 + 64 + 1.
    vld8 = 1'b1; prod8 = 8'sd64;
    step();
    step();
    chk("sticky_mid", int'(ovf8), 1);
    lst8 = 1'b1; prod8 = 8'sd1;
    step();
    vld8 = 1'b0; lst8 = 1'b0;
    chk("sticky_flag", int'(ovf8), 1);
`ifdef MAC_SATURATE_EN
    chk("sticky_res", int'(res8), 127);
`else
    chk("sticky_res", int'(res8), -127);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
